cache_l1i_nway: RTL and testbench

Parametrised set-associative L1 instruction cache between the fetch stage and the qword instruction bus. Geometry (sets, ways, line length) is configurable. Refills use multi-beat line bursts with round-robin replacement, and a single-cycle invalidate-all input is provided. Hits return a 32-bit word one cycle after request.

---
 rtl/cache_l1i_nway.sv | 237 +++++++++++++++++++++++
 tb/tb_cache_l1i_nway.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/cache_l1i_nway.sv
// cache_l1i_nway: set-associative L1 instruction cache with burst line refill and round-robin replacement.
// Optional hit/miss counters (stat_hits/stat_misses) are built in when L1I_STATS_EN is defined.

module cache_l1i_way #(
  parameter int SETS        = 64,
  parameter int LINE_QWORDS = 4,
  parameter int IW          = 6,
  parameter int DAW         = 8,
  parameter int TW          = 21
) (
  input  logic           clk,
  input  logic           we_i,
  input  logic [DAW-1:0] waddr_i,
  input  logic [63:0]    wdata_i,
  input  logic           tag_we_i,
  input  logic [IW-1:0]  tidx_i,
  input  logic [TW-1:0]  tag_i,
  input  logic [DAW-1:0] raddr_i,
  output logic [63:0]    rdata_o,
  input  logic [IW-1:0]  ridx_i,
  output logic [TW-1:0]  rtag_o
);
  logic [63:0]   data_q [SETS*LINE_QWORDS];
  logic [TW-1:0] tag_q  [SETS];

  always_ff @(posedge clk) begin
    if (we_i)     data_q[waddr_i] <= wdata_i;
    if (tag_we_i) tag_q[tidx_i]   <= tag_i;
  end

  assign rdata_o = data_q[raddr_i];
  assign rtag_o  = tag_q[ridx_i];
endmodule

module cache_l1i_nway #(
  parameter int SETS        = 64,
  parameter int WAYS        = 2,
  parameter int LINE_QWORDS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_start,
  input  logic [29:0] fetch_addr,
  input  logic        flush,
  output logic        fetch_ready,
  output logic [31:0] fetch_data_rd,
  output logic        insn_start,
  output logic [28:0] insn_addr,
  input  logic        insn_ready,
  input  logic [63:0] insn_data_rd
`ifdef L1I_STATS_EN
  ,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_misses
`endif
);
  localparam int BW  = $clog2(LINE_QWORDS);
  localparam int IW  = $clog2(SETS);
  localparam int WW  = $clog2(WAYS);
  localparam int BWX = (BW > 0) ? BW : 1;
  localparam int WWX = (WW > 0) ? WW : 1;
  localparam int DAW = IW + BW;
  localparam int TW  = 29 - DAW;
  localparam logic [28:0] BMASK = 29'(LINE_QWORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_FILL, S_RESP} state_t;

  state_t                      state_q;
  logic [29:0]                 addr_q;
  logic                        hit_q, flushed_q;
  logic [BWX-1:0]              beat_q;
  logic [WWX-1:0]              victim_q, victim_d;
  logic                        fetch_ready_q, insn_start_q;
  logic [31:0]                 fetch_data_q;
  logic [28:0]                 insn_addr_q;
  logic [SETS-1:0][WAYS-1:0]   valid_q;
  logic [SETS-1:0][WWX-1:0]    vptr_q;

  // Lookup runs on the incoming address so the hit response can be registered.
  logic [28:0]    f_qa, q_qa;
  logic [IW-1:0]  f_idx, q_idx;
  logic [TW-1:0]  f_tag, q_tag;
  logic [DAW-1:0] f_da, fill_da;
  logic           acc, lk_miss, last_beat, fill_done;

  assign f_qa      = fetch_addr[29:1];
  assign f_idx     = f_qa[DAW-1:BW];
  assign f_tag     = f_qa[28:DAW];
  assign f_da      = f_qa[DAW-1:0];
  assign q_qa      = addr_q[29:1];
  assign q_idx     = q_qa[DAW-1:BW];
  assign q_tag     = q_qa[28:DAW];
  assign fill_da   = (DAW'(q_idx) << BW) | DAW'(beat_q);
  assign acc       = fetch_start && (state_q == S_IDLE || fetch_ready_q);
  assign lk_miss   = (state_q == S_LOOKUP) && !hit_q;
  assign last_beat = (beat_q == BWX'(LINE_QWORDS - 1));
  assign fill_done = (state_q == S_FILL) && insn_ready && last_beat;

  logic [WAYS-1:0][63:0]   rdata;
  logic [WAYS-1:0][TW-1:0] rtag;
  logic [WAYS-1:0]         hit_vec;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    cache_l1i_way #(.SETS(SETS), .LINE_QWORDS(LINE_QWORDS), .IW(IW), .DAW(DAW), .TW(TW)) u_way (
      .clk      (clk),
      .we_i     ((state_q == S_FILL) && insn_ready && (victim_q == WWX'(w))),
      .waddr_i  (fill_da),
      .wdata_i  (insn_data_rd),
      .tag_we_i (fill_done && (victim_q == WWX'(w))),
      .tidx_i   (q_idx),
      .tag_i    (q_tag),
      .raddr_i  (f_da),
      .rdata_o  (rdata[w]),
      .ridx_i   (f_idx),
      .rtag_o   (rtag[w])
    );
    assign hit_vec[w] = valid_q[f_idx][w] && !flush && (rtag[w] == f_tag);
  end

  logic [63:0] hit_qw;
  logic [31:0] hit_word, fill_word;

  always_comb begin
    hit_qw = '0;
    for (int w = 0; w < WAYS; w++)
      if (hit_vec[w]) hit_qw = hit_qw | rdata[w];
    hit_word  = fetch_addr[0] ? hit_qw[63:32] : hit_qw[31:0];
    fill_word = addr_q[0] ? insn_data_rd[63:32] : insn_data_rd[31:0];
  end

  // First invalid way wins; only a full set falls back to the round-robin pointer.
  always_comb begin
    victim_d = vptr_q[q_idx];
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_q[q_idx][w]) victim_d = WWX'(w);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      hit_q         <= 1'b0;
      flushed_q     <= 1'b0;
      beat_q        <= '0;
      victim_q      <= '0;
      fetch_ready_q <= 1'b0;
      fetch_data_q  <= '0;
      insn_start_q  <= 1'b0;
      insn_addr_q   <= '0;
    end else begin
      fetch_ready_q <= 1'b0;
      case (state_q)
        S_LOOKUP: begin
          if (!hit_q) begin
            state_q      <= S_FILL;
            victim_q     <= victim_d;
            beat_q       <= '0;
            flushed_q    <= 1'b0;
            insn_start_q <= 1'b1;
            insn_addr_q  <= q_qa & ~BMASK;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_FILL: begin
          if (flush) flushed_q <= 1'b1;
          if (insn_ready) begin
            if (BWX'(q_qa & BMASK) == beat_q) fetch_data_q <= fill_word;
            if (last_beat) begin
              insn_start_q  <= 1'b0;
              fetch_ready_q <= 1'b1;
              state_q       <= S_RESP;
            end else begin
              beat_q      <= beat_q + 1'b1;
              insn_addr_q <= insn_addr_q + 29'd1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
      if (acc) begin
        addr_q        <= fetch_addr;
        hit_q         <= |hit_vec;
        fetch_ready_q <= |hit_vec;
        if (|hit_vec) fetch_data_q <= hit_word;
        state_q       <= S_LOOKUP;
      end
    end
  end

  // A flush seen anywhere in the burst keeps the refilled line invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      vptr_q  <= '0;
    end else begin
      if (flush) valid_q <= '0;
      if (lk_miss) begin
        valid_q[q_idx][victim_d] <= 1'b0;
        if (&valid_q[q_idx])
          vptr_q[q_idx] <= (vptr_q[q_idx] == WWX'(WAYS - 1)) ? '0 : vptr_q[q_idx] + 1'b1;
      end
      if (fill_done && !flush && !flushed_q) valid_q[q_idx][victim_q] <= 1'b1;
    end
  end

  assign fetch_ready   = fetch_ready_q;
  assign fetch_data_rd = fetch_data_q;
  assign insn_start    = insn_start_q;
  assign insn_addr     = insn_addr_q;

`ifdef L1I_STATS_EN
  logic [31:0] hits_q, misses_q, hits_d, misses_d, hits_b, misses_b;

  always_comb begin
    hits_b   = flush ? '0 : hits_q;
    misses_b = flush ? '0 : misses_q;
    hits_d   = hits_b;
    misses_d = misses_b;
    if (state_q == S_LOOKUP && hit_q && !(&hits_b))    hits_d   = hits_b + 32'd1;
    if (state_q == S_LOOKUP && !hit_q && !(&misses_b)) misses_d = misses_b + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      hits_q   <= hits_d;
      misses_q <= misses_d;
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
`endif
endmodule

// File: tb/tb_cache_l1i_nway.sv
// Directed bench for cache_l1i_nway (SETS=64, WAYS=2, LINE_QWORDS=4); bus beat data is {0x1000_0000+qaddr, 0x2000_0000+qaddr}.
module tb_cache_l1i_nway;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        fetch_start = 1'b0, flush = 1'b0, insn_ready = 1'b0;
  logic [29:0] fetch_addr = '0;
  logic [63:0] insn_data_rd = '0;
  logic        fetch_ready, insn_start;
  logic [31:0] fetch_data_rd;
  logic [28:0] insn_addr;
`ifdef L1I_STATS_EN
  logic [31:0] stat_hits, stat_misses;
`endif

  int nvec = 0, nerr = 0, cyc = 0;
  logic [28:0] addr_log[$];
  int stall_n = 0, stall_seen = 0, last_rdy_cyc = 0;
  logic [28:0] stall_addr = '0;

  cache_l1i_nway #(.SETS(64), .WAYS(2), .LINE_QWORDS(4)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_start(fetch_start), .fetch_addr(fetch_addr), .flush(flush),
    .fetch_ready(fetch_ready), .fetch_data_rd(fetch_data_rd), .insn_start(insn_start),
    .insn_addr(insn_addr), .insn_ready(insn_ready), .insn_data_rd(insn_data_rd)
`ifdef L1I_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus responder: accepts each beat in the cycle it is requested unless a stall is armed.
  initial begin
    forever begin
      @(posedge clk); #1;
      insn_ready = 1'b0;
      if (insn_start === 1'b1) begin
        if (stall_n > 0 && insn_addr === stall_addr) begin
          stall_n--; stall_seen++;
        end else begin
          insn_ready   = 1'b1;
          insn_data_rd = {32'h1000_0000 + 32'(insn_addr), 32'h2000_0000 + 32'(insn_addr)};
          addr_log.push_back(insn_addr);
          last_rdy_cyc = cyc;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic fetch(input logic [29:0] a, input bit with_flush, output logic [31:0] d, output int lat, output int rcyc);
    @(posedge clk); #1;
    fetch_start = 1'b1; fetch_addr = a; flush = with_flush;
    @(posedge clk); #1;
    fetch_start = 1'b0; flush = 1'b0; lat = 1;
    while (fetch_ready !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
    if (fetch_ready !== 1'b1) lat = -1;
    d = fetch_data_rd; rcyc = cyc;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    nvec++; if (fetch_ready !== 1'b0) begin nerr++; $display("FAIL rst_fetch_ready got %b want 0", fetch_ready); end
    nvec++; if (fetch_data_rd !== 32'h0) begin nerr++; $display("FAIL rst_fetch_data got %h want 0", fetch_data_rd); end
    nvec++; if (insn_start !== 1'b0) begin nerr++; $display("FAIL rst_insn_start got %b want 0", insn_start); end
    nvec++; if (insn_addr !== 29'h0) begin nerr++; $display("FAIL rst_insn_addr got %h want 0", insn_addr); end
`ifdef L1I_STATS_EN
    nvec++; if (stat_hits !== 0 || stat_misses !== 0) begin nerr++; $display("FAIL rst_stats got %0d/%0d want 0/0", stat_hits, stat_misses); end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_cold_miss;
    logic [31:0] d; int lat, rc;
    addr_log.delete();
    fetch(30'h045, 1'b0, d, lat, rc);
    nvec++; if (lat !== 6) begin nerr++; $display("FAIL cold_lat got %0d want 6", lat); end
    nvec++; if (d !== 32'h1000_0022) begin nerr++; $display("FAIL cold_data got %h want 10000022", d); end
    nvec++; if (addr_log.size() !== 4) begin nerr++; $display("FAIL cold_beats got %0d want 4", addr_log.size()); end
    for (int i = 0; i < 4 && i < addr_log.size(); i++) begin
      nvec++; if (addr_log[i] !== 29'h20 + 29'(i)) begin nerr++; $display("FAIL cold_beat%0d got %h want %h", i, addr_log[i], 29'h20 + 29'(i)); end
    end
    addr_log.delete();
    fetch(30'h044, 1'b0, d, lat, rc);
    nvec++; if (lat !== 1) begin nerr++; $display("FAIL hit_lat got %0d want 1", lat); end
    nvec++; if (d !== 32'h2000_0022) begin nerr++; $display("FAIL hit_data got %h want 20000022", d); end
    nvec++; if (addr_log.size() !== 0) begin nerr++; $display("FAIL hit_bus got %0d beats want 0", addr_log.size()); end
  endtask

  task automatic test_back_to_back;
    logic [29:0] a[4] = '{30'h044, 30'h045, 30'h046, 30'h047};
    logic [31:0] e[4] = '{32'h2000_0022, 32'h1000_0022, 32'h2000_0023, 32'h1000_0023};
    addr_log.delete();
    @(posedge clk); #1;
    fetch_start = 1'b1; fetch_addr = a[0];
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      nvec++; if (fetch_ready !== 1'b1 || fetch_data_rd !== e[k]) begin nerr++; $display("FAIL b2b_%0d got rdy=%b data=%h want rdy=1 data=%h", k, fetch_ready, fetch_data_rd, e[k]); end
      if (k < 3) fetch_addr = a[k+1]; else fetch_start = 1'b0;
    end
    @(posedge clk); #1;
    nvec++; if (fetch_ready !== 1'b0) begin nerr++; $display("FAIL b2b_end got rdy=%b want 0", fetch_ready); end
    nvec++; if (addr_log.size() !== 0) begin nerr++; $display("FAIL b2b_bus got %0d beats want 0", addr_log.size()); end
  endtask

  task automatic test_conflict;
    logic [29:0] a[7]  = '{30'h000, 30'h200, 30'h400, 30'h200, 30'h000, 30'h400, 30'h200};
    int          el[7] = '{6, 6, 6, 1, 6, 1, 6};
    logic [31:0] e[7]  = '{32'h2000_0000, 32'h2000_0100, 32'h2000_0200, 32'h2000_0100,
                           32'h2000_0000, 32'h2000_0200, 32'h2000_0100};
    logic [31:0] d; int lat, rc;
    for (int i = 0; i < 7; i++) begin
      fetch(a[i], 1'b0, d, lat, rc);
      nvec++; if (lat !== el[i] || d !== e[i]) begin nerr++; $display("FAIL conflict_%0d addr %h got lat=%0d data=%h want lat=%0d data=%h", i, a[i], lat, d, el[i], e[i]); end
    end
  endtask

  task automatic test_flush;
    logic [31:0] d; int lat, rc;
    fetch(30'h000, 1'b0, d, lat, rc);
    nvec++; if (lat !== 1) begin nerr++; $display("FAIL flush_pre_hit got lat=%0d want 1", lat); end
    @(posedge clk); #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    addr_log.delete();
    fetch(30'h000, 1'b0, d, lat, rc);
    nvec++; if (lat !== 6 || d !== 32'h2000_0000) begin nerr++; $display("FAIL flush_miss got lat=%0d data=%h want lat=6 data=20000000", lat, d); end
    nvec++; if (addr_log.size() !== 4) begin nerr++; $display("FAIL flush_beats got %0d want 4", addr_log.size()); end
`ifdef L1I_STATS_EN
    nvec++; if (stat_hits !== 0 || stat_misses !== 1) begin nerr++; $display("FAIL flush_stats got %0d/%0d want 0/1", stat_hits, stat_misses); end
`endif
    fetch(30'h000, 1'b0, d, lat, rc);
    nvec++; if (lat !== 1) begin nerr++; $display("FAIL flush_rehit got lat=%0d want 1", lat); end
    fetch(30'h000, 1'b1, d, lat, rc);
    nvec++; if (lat !== 6) begin nerr++; $display("FAIL flush_same_cycle got lat=%0d want 6", lat); end
`ifdef L1I_STATS_EN
    nvec++; if (stat_hits !== 0 || stat_misses !== 1) begin nerr++; $display("FAIL flush_same_stats got %0d/%0d want 0/1", stat_hits, stat_misses); end
`endif
    fork
      fetch(30'h201, 1'b0, d, lat, rc);
      begin
        repeat (4) @(posedge clk);
        #2 flush = 1'b1;
        @(posedge clk);
        #2 flush = 1'b0;
      end
    join
    nvec++; if (lat !== 6 || d !== 32'h1000_0100) begin nerr++; $display("FAIL flush_mid_fill got lat=%0d data=%h want lat=6 data=10000100", lat, d); end
    fetch(30'h201, 1'b0, d, lat, rc);
    nvec++; if (lat !== 6) begin nerr++; $display("FAIL flush_mid_refetch got lat=%0d want 6", lat); end
  endtask

  task automatic test_stall;
    logic [31:0] d; int lat, rc;
    addr_log.delete();
    stall_addr = 29'h022; stall_seen = 0; stall_n = 5;
    fetch(30'h045, 1'b0, d, lat, rc);
    nvec++; if (stall_seen !== 5) begin nerr++; $display("FAIL stall_stable got %0d cycles want 5", stall_seen); end
    nvec++; if (lat !== 11 || d !== 32'h1000_0022) begin nerr++; $display("FAIL stall_resp got lat=%0d data=%h want lat=11 data=10000022", lat, d); end
    nvec++; if (rc !== last_rdy_cyc + 1) begin nerr++; $display("FAIL stall_ready_gap got cyc %0d want %0d", rc, last_rdy_cyc + 1); end
    nvec++; if (addr_log.size() !== 4) begin nerr++; $display("FAIL stall_beats got %0d want 4", addr_log.size()); end
  endtask

  task automatic test_reset_fill;
    logic [31:0] d; int lat, rc; bit found = 0, seen_rdy = 0;
    @(posedge clk); #1;
    fetch_start = 1'b1; fetch_addr = 30'h105;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #1;
      fetch_start = 1'b0;
      if (insn_start === 1'b1 && insn_addr === 29'h081) found = 1;
    end
    nvec++; if (!found) begin nerr++; $display("FAIL rstfill_beat1 got none want insn_addr 081"); end
    #2 rst_n = 1'b0;
    #1;
    nvec++; if (insn_start !== 1'b0 || insn_addr !== 29'h0) begin nerr++; $display("FAIL rstfill_async got start=%b addr=%h want 0/0", insn_start, insn_addr); end
    repeat (3) begin @(posedge clk); #1; if (fetch_ready !== 1'b0) seen_rdy = 1; end
    nvec++; if (seen_rdy) begin nerr++; $display("FAIL rstfill_no_ready got 1 want 0"); end
    rst_n = 1'b1;
    addr_log.delete();
    fetch(30'h105, 1'b0, d, lat, rc);
    nvec++; if (lat !== 6 || d !== 32'h1000_0082) begin nerr++; $display("FAIL rstfill_refetch got lat=%0d data=%h want lat=6 data=10000082", lat, d); end
    nvec++; if (addr_log.size() !== 4) begin nerr++; $display("FAIL rstfill_beats got %0d want 4", addr_log.size()); end
  endtask

  initial begin
    test_reset;
    test_cold_miss;
    test_back_to_back;
    test_conflict;
    test_flush;
    test_stall;
    test_reset_fill;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
